// File: rtl/tick_gen_pkg.sv
// tick_gen shared definitions: default rates and width helper.
package tick_gen_pkg;

    localparam int DEF_DIV      = 50_000_000;
    localparam int DEF_SCAN_DIV = 8192;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_gen_if.sv
// tick_gen control/status bundle: divisor writes, enables, tick outputs.
interface tick_gen_if
    import tick_gen_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 26,
    parameter int SCAN_W = 2
);

    localparam int SEL_W = clog2_min1(N_CH);

    logic [N_CH-1:0]   ch_en;
    logic              div_load;
    logic [SEL_W-1:0]  div_sel;
    logic [CNT_W-1:0]  div_val;
    logic              sync_clr;
    logic [N_CH-1:0]   tick;
    logic [N_CH-1:0]   level;
    logic [SCAN_W-1:0] scan;

    modport master (
        output ch_en, div_load, div_sel, div_val, sync_clr,
        input  tick, level, scan
    );

    modport slave (
        input  ch_en, div_load, div_sel, div_val, sync_clr,
        output tick, level, scan
    );

endinterface

// File: rtl/tick_chan.sv
// One divider slice: counter, active/shadow divisor, tick and level.
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int CNT_W       = 26,
    parameter int DIV_DEFAULT = DEF_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_val,
    input  logic             clr,
    output logic             tick,
    output logic             level
);

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] div_sh;
        logic             pend;
    } chan_st_t;

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);

    chan_st_t st_q, st_d;
    logic     tick_d, level_d;
    logic     run, wrap, promote;

    always_comb begin
        run     = en && (st_q.div != '0);
        wrap    = run && (st_q.cnt == st_q.div - CNT_W'(1));
        // Idle channels take a pending divisor at once; running ones only at wrap
        promote = st_q.pend && (wrap || !run);
        st_d    = st_q;
        tick_d  = 1'b0;
        level_d = level;
        if (wr) st_d.div_sh = wr_val;
        if (clr) begin
            st_d.cnt  = '0;
            level_d   = 1'b0;
            st_d.pend = 1'b0;
            if (wr)
                st_d.div = wr_val;
            else if (st_q.pend)
                st_d.div = st_q.div_sh;
        end else begin
            tick_d  = wrap;
            level_d = level ^ wrap;
            if (wrap)
                st_d.cnt = '0;
            else if (run)
                st_d.cnt = st_q.cnt + CNT_W'(1);
            if (promote) st_d.div = st_q.div_sh;
            st_d.pend = wr || (st_q.pend && !promote);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= '{cnt: '0, div: DIV_RST,
                       div_sh: DIV_RST, pend: 1'b0};
            tick  <= 1'b0;
            level <= 1'b0;
        end else begin
            st_q  <= st_d;
            tick  <= tick_d;
            level <= level_d;
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator with free-running display scan index.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 26,
    parameter int DIV_DEFAULT = DEF_DIV,
    parameter int SCAN_W      = 2,
    parameter int SCAN_DIV    = DEF_SCAN_DIV
) (
    input logic       clk,
    input logic       rst_n,
    tick_gen_if.slave bus
);

    localparam int SEL_W = clog2_min1(N_CH);
    localparam int SC_W  = clog2_min1(SCAN_DIV);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_DIV - 1);

    logic [N_CH-1:0]   wr;
    logic [N_CH-1:0]   tick_w;
    logic [N_CH-1:0]   level_w;
    logic [SC_W-1:0]   scnt;
    logic [SCAN_W-1:0] scan_q;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        // Selector values beyond N_CH-1 match no channel and are dropped
        assign wr[gi] = bus.div_load && (bus.div_sel == SEL_W'(gi));

        tick_chan #(
            .CNT_W       (CNT_W),
            .DIV_DEFAULT (DIV_DEFAULT)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (bus.ch_en[gi]),
            .wr     (wr[gi]),
            .wr_val (bus.div_val),
            .clr    (bus.sync_clr),
            .tick   (tick_w[gi]),
            .level  (level_w[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt   <= '0;
            scan_q <= '0;
        end else if (bus.sync_clr) begin
            scnt   <= '0;
            scan_q <= '0;
        end else if (scnt == SC_LAST) begin
            scnt   <= '0;
            scan_q <= scan_q + SCAN_W'(1);
        end else begin
            scnt   <= scnt + SC_W'(1);
        end
    end

    assign bus.tick  = tick_w;
    assign bus.level = level_w;
    assign bus.scan  = scan_q;

endmodule

// File: tb/tb_tick_gen.sv
// Randomized bench for tick_gen against a period-based reference model.
module tb_tick_gen;

    localparam int NC = 4;
    localparam int CW = 8;
    localparam int DD = 5;
    localparam int SW = 2;
    localparam int SD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    tick_gen_if #(.N_CH(NC), .CNT_W(CW), .SCAN_W(SW)) bus ();

    tick_gen #(
        .N_CH        (NC),
        .CNT_W       (CW),
        .DIV_DEFAULT (DD),
        .SCAN_W      (SW),
        .SCAN_DIV    (SD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    // model: elapsed cycles in current period, period, queued period
    int elapsed [NC];
    int period  [NC];
    int queued  [NC];
    bit has_q   [NC];
    bit m_lvl   [NC];
    bit m_tick  [NC];
    int cycles;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NC; i++) begin
            elapsed[i] = 0;
            period[i]  = DD;
            queued[i]  = DD;
            has_q[i]   = 1'b0;
            m_lvl[i]   = 1'b0;
            m_tick[i]  = 1'b0;
        end
        cycles = 0;
    endtask

    task automatic model_step();
        bit w, done, idle, take;
        int v;
        v = int'(bus.div_val);
        for (int i = 0; i < NC; i++) begin
            w = bus.div_load && (int'(bus.div_sel) == i);
            if (bus.sync_clr) begin
                if (w) period[i] = v;
                else if (has_q[i]) period[i] = queued[i];
                if (w) queued[i] = v;
                has_q[i]   = 1'b0;
                elapsed[i] = 0;
                m_lvl[i]   = 1'b0;
                m_tick[i]  = 1'b0;
            end else begin
                idle = !bus.ch_en[i] || period[i] == 0;
                done = !idle && (elapsed[i] + 1 == period[i]);
                m_tick[i] = done;
                if (done) begin
                    elapsed[i] = 0;
                    m_lvl[i]   = !m_lvl[i];
                end else if (!idle) begin
                    elapsed[i]++;
                end
                take = has_q[i] && (done || idle);
                if (take) period[i] = queued[i];
                has_q[i] = w || (has_q[i] && !take);
                if (w) queued[i] = v;
            end
        end
        cycles = bus.sync_clr ? 0 : cycles + 1;
    endtask

    function automatic logic [NC-1:0] exp_tick();
        logic [NC-1:0] r;
        for (int i = 0; i < NC; i++) r[i] = m_tick[i];
        return r;
    endfunction

    function automatic logic [NC-1:0] exp_lvl();
        logic [NC-1:0] r;
        for (int i = 0; i < NC; i++) r[i] = m_lvl[i];
        return r;
    endfunction

    task automatic cmp_all();
        chk("tick", bus.tick, exp_tick());
        chk("level", bus.level, exp_lvl());
        chk("scan", bus.scan, (cycles / SD) % (1 << SW));
    endtask

    task automatic edge_chk();
        model_step();
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    initial begin
        bus.ch_en    = '1;
        bus.div_load = 1'b0;
        bus.div_sel  = '0;
        bus.div_val  = '0;
        bus.sync_clr = 1'b0;
        model_reset();
        #12;
        chk("rst_tick", bus.tick, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_scan", bus.scan, 0);
        rst_n = 1'b1;

        for (int e = 1; e <= 16; e++) begin
            edge_chk();
            if (e == 4)  chk("scan_e4", bus.scan, 1);
            if (e == 5)  chk("tick_e5", bus.tick, 4'hF);
            if (e == 5)  chk("lvl_e5", bus.level, 4'hF);
            if (e == 10) chk("lvl_e10", bus.level, 4'h0);
            if (e == 15) chk("tick_e15", bus.tick, 4'hF);
            if (e == 16) chk("scan_e16", bus.scan, 0);
        end

        bus.div_load = 1'b1;
        bus.div_sel  = 2'd2;
        bus.div_val  = 8'd1;
        edge_chk();
        bus.div_load = 1'b0;
        for (int e = 0; e < 6; e++) edge_chk();
        chk("div1_tick", bus.tick[2], 1);

        bus.sync_clr = 1'b1;
        edge_chk();
        chk("clr_tick", bus.tick, 0);
        chk("clr_level", bus.level, 0);
        chk("clr_scan", bus.scan, 0);
        bus.sync_clr = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0)
                bus.ch_en[$urandom_range(0, NC - 1)] ^= 1'b1;
            bus.div_load = ($urandom_range(0, 5) == 0);
            bus.div_sel  = SW'($urandom_range(0, NC - 1));
            bus.div_val  = CW'($urandom_range(0, 7));
            bus.sync_clr = ($urandom_range(0, 59) == 0);
            edge_chk();
            if (c == 2000) begin
                rst_n = 1'b0;
                #1;
                chk("mid_rst_tick", bus.tick, 0);
                chk("mid_rst_level", bus.level, 0);
                chk("mid_rst_scan", bus.scan, 0);
                model_reset();
                #2;
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
